// File: rtl/kcore_start_token_sched.sv
// Start/done sequencer for the kcore dataflow region: broadcasts start tokens and retires completed iterations.
// Optional performance counters are enabled by defining KCORE_START_SCHED_PERF_EN.
module kcore_start_token_sched #(
    parameter int NUM_TASK     = 4,
    parameter int MAX_INFLIGHT = 2,
    parameter int CNT_W        = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ap_start,
    output logic                ap_ready,
    output logic                ap_done,
    input  logic                ap_continue,
    output logic                ap_idle,
    output logic [NUM_TASK-1:0] tok_write,
    input  logic [NUM_TASK-1:0] tok_full_n,
    input  logic [NUM_TASK-1:0] task_done,
    output logic [CNT_W-1:0]    inflight
`ifdef KCORE_START_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_busy_cycles,
    output logic [31:0]         perf_stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] dcnt     [NUM_TASK];
    logic [CNT_W-1:0] dcnt_nxt [NUM_TASK];
    logic             issue;
    logic             retire;
    logic             all_have_done;

    // Broadcast is all-or-nothing: every FIFO must have room before any strobe fires.
    assign issue     = ap_start && (inflight < MAX_C) && (&tok_full_n);
    assign ap_ready  = issue;
    assign tok_write = {NUM_TASK{issue}};
    assign retire    = all_have_done && (!ap_done || ap_continue);
    assign ap_idle   = (inflight == '0) && !ap_done;

    always_comb begin
        all_have_done = 1'b1;
        for (int unsigned i = 0; i < NUM_TASK; i++) begin
            if (dcnt[i] == '0) all_have_done = 1'b0;
        end
    end

    // A completion beyond the in-flight count is a protocol violation and is dropped.
    always_comb begin
        for (int unsigned i = 0; i < NUM_TASK; i++) begin
            dcnt_nxt[i] = dcnt[i];
            if (task_done[i] && (dcnt[i] != inflight) && (dcnt[i] != MAX_C)) begin
                if (!retire) dcnt_nxt[i] = dcnt[i] + 1'b1;
            end else if (retire) begin
                dcnt_nxt[i] = dcnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
            ap_done  <= 1'b0;
            for (int unsigned i = 0; i < NUM_TASK; i++) dcnt[i] <= '0;
        end else begin
            inflight <= inflight + CNT_W'(issue) - CNT_W'(retire);
            ap_done  <= retire || (ap_done && !ap_continue);
            for (int unsigned i = 0; i < NUM_TASK; i++) dcnt[i] <= dcnt_nxt[i];
        end
    end

`ifdef KCORE_START_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (inflight != '0)      perf_busy_cycles  <= perf_busy_cycles + 32'd1;
            if (ap_start && !issue)  perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
